imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory writer: receives a byte stream (header, program words, checksum) and writes 32-bit words into the four byte-wide instruction banks that the fetch stage reads through `PC[15:2]`. It holds the CPU (`cpu_hold` → fetch `stall` / `PC_enable` low) until a complete, checksum-verified image is written. It sits between the host byte link (UART/debug bridge) and the instruction bank write ports.

## Interface
- `ADDR_W`, 14: word-address width; matches the bank address `PC[15:2]`.
- `MAX_WORDS`, 16384: largest accepted image, in words; must be ≤ 2^ADDR_W.

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a load; sampled only in IDLE, DONE or ERR
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  loader accepts a byte this cycle
- `mem_addr`  out  ADDR_W  word address to all four banks
- `mem_wdata`  out  32  `{bank3, bank2, bank1, bank0}` byte data
- `mem_we`  out  4  per-bank write enables; bit i drives bank i
- `cpu_hold`  out  1  keeps the CPU stalled; low only in DONE
- `done`  out  1  image loaded and checksum good
- `error`  out  1  load aborted (oversize image or bad checksum)
- `words_loaded`  out  ADDR_W+1  count of words written in the current load

## Operation
- Byte transfer: a byte is accepted on a rising edge where `rx_valid & rx_ready` is high. `rx_valid` may drop at any time. `rx_data` is ignored when no byte is accepted.
- Stream format: 4 header bytes giving the 32-bit word count N, little-endian. Then 4·N data bytes, little-endian per word: the first byte goes to bank0, the fourth to bank3. Then 1 checksum byte C.
- Checksum rule: the sum of all data bytes plus C, mod 256, must equal 0. Header bytes are excluded from the sum.
- States:
  - IDLE: `rx_ready`=0. On `start`, clear counters and the checksum accumulator, then go to HDR.
  - HDR: `rx_ready`=1. Assemble 4 bytes into N.
    - After the 4th byte: N > MAX_WORDS → ERR; N = 0 → CHK; otherwise → DATA.
  - DATA: `rx_ready`=1. Shift each byte into the word register and add it to the checksum.
    - When the 4th byte of a word is accepted, issue a write and increment the word index.
    - After word N-1's 4th byte → CHK.
  - CHK: `rx_ready`=1. Accept C. Good checksum → DONE; bad → ERR.
  - DONE: `done`=1, `cpu_hold`=0, `rx_ready`=0. `start` → HDR with `cpu_hold` re-asserted.
  - ERR: `error`=1, `cpu_hold`=1, `rx_ready`=0. `start` → HDR.
- `done` and `error` clear on the cycle the FSM enters HDR.
- `start` is ignored in HDR, DATA and CHK.
- The word index saturates at N. `words_loaded` is the number of completed writes.
- No read port. No write ever occurs outside DATA or the write cycle that immediately follows it.
- Bytes offered while `rx_ready`=0 are not consumed. The source holds them.

## Timing
- Reset values: FSM=IDLE, `rx_ready`=0, `mem_we`=4'h0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0, `words_loaded`=0.
- Reset mid-load: the FSM returns to IDLE immediately. Already-written bank words are left as they are; no further writes occur.
- `start` accepted at edge t → HDR from t+1, so `rx_ready`=1 in cycle t+1.
- Write latency: word k's 4th byte accepted at edge t →
  - `mem_we`=4'hF, `mem_addr`=k and `mem_wdata`=word are driven during cycle t+1, for exactly one cycle;
  - `words_loaded`=k+1 from t+1.
- Throughput: 1 byte/cycle sustained. `rx_ready` stays high during write cycles.
- Last-word write overlaps CHK. Checksum accepted at edge t → `done` or `error` high from t+1. This is never before the last write cycle.
- Oversize header: 4th header byte at edge t → `error` from t+1. `rx_ready`=0 from t+1. No writes.

## Test plan
- Reset: assert `rst_n`=0 with random inputs → all outputs at reset values; `cpu_hold`=1; `mem_we`=0.
- Two-word load, streamed back-to-back: `start`, then 02 00 00 00, 13 00 00 00, 78 56 34 12, D9 →
  - write addr 0 = 0x00000013, addr 1 = 0x12345678, each `mem_we`=4'hF for one cycle;
  - `done`=1, `cpu_hold`=0, `words_loaded`=2.
- Same stream with checksum DA → both writes occur; then `error`=1, `done`=0, `cpu_hold`=1.
- Header 01 40 00 00 (N=0x4001 > 16384) → `error` one cycle after the 4th byte; zero writes; `rx_ready`=0. Header 00 00 00 00 followed by C=00 → `done`=1 with no writes.
- Back-pressure: the two-word stream with `rx_valid` toggling every other cycle, and `start` pulsed during DATA → results identical to the back-to-back case; `start` has no effect.
- Reset mid-load after word 0 is written, then a full two-word reload → word 0 is not rewritten before the new load starts; the reload completes with `done`=1 and `words_loaded`=2.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a header/data/checksum byte stream
// and writes 32-bit words into the four byte-wide instruction banks.
module imem_loader #(
   parameter int ADDR_W    = 14,
   parameter int MAX_WORDS = 16384
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_we,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE, ERR} state_t;

   localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

   state_t          state;
   logic [1:0]      byte_cnt;
   logic [31:0]     hdr;
   logic [ADDR_W:0] n_cnt;
   logic [ADDR_W:0] word_idx;
   logic [7:0]      csum;
   logic [23:0]     word_sr;

   logic            acc;
   logic [31:0]     hdr_next;
   logic [7:0]      csum_next;
   logic [ADDR_W:0] idx_next;

   assign acc       = rx_valid & rx_ready;
   assign hdr_next  = {rx_data, hdr[31:8]};
   assign csum_next = csum + rx_data;
   assign idx_next  = word_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         byte_cnt     <= '0;
         hdr          <= '0;
         n_cnt        <= '0;
         word_idx     <= '0;
         csum         <= '0;
         word_sr      <= '0;
         rx_ready     <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_we       <= 4'h0;
         cpu_hold     <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
      end else begin
         mem_we <= 4'h0;
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state        <= HDR;
                  byte_cnt     <= '0;
                  hdr          <= '0;
                  word_idx     <= '0;
                  csum         <= '0;
                  words_loaded <= '0;
                  rx_ready     <= 1'b1;
                  cpu_hold     <= 1'b1;
                  done         <= 1'b0;
                  error        <= 1'b0;
               end
            end
            HDR: begin
               if (acc) begin
                  hdr      <= hdr_next;
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == 2'd3) begin
                     // Reject oversize images before any bank is touched.
                     if (hdr_next > MAX_N) begin
                        state    <= ERR;
                        error    <= 1'b1;
                        rx_ready <= 1'b0;
                     end else begin
                        n_cnt <= hdr_next[ADDR_W:0];
                        state <= (hdr_next == 32'd0) ? CHK : DATA;
                     end
                  end
               end
            end
            DATA: begin
               if (acc) begin
                  csum     <= csum_next;
                  byte_cnt <= byte_cnt + 1'b1;
                  word_sr  <= {rx_data, word_sr[23:8]};
                  if (byte_cnt == 2'd3) begin
                     mem_we       <= 4'hF;
                     mem_addr     <= word_idx[ADDR_W-1:0];
                     mem_wdata    <= {rx_data, word_sr};
                     word_idx     <= idx_next;
                     words_loaded <= idx_next;
                     if (idx_next == n_cnt)
                        state <= CHK;
                  end
               end
            end
            CHK: begin
               if (acc) begin
                  rx_ready <= 1'b0;
                  if (csum_next == 8'd0) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               rx_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed vectors, corner sequences and randomized streams
// checked against a stream-level reference model.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_we;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [14:0] words_loaded;

   imem_loader #(.ADDR_W(14), .MAX_WORDS(16384)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .cpu_hold(cpu_hold),
      .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [13:0] a;
      logic [31:0] d;
      logic [3:0]  we;
   } wr_t;

   typedef struct {
      string        name;
      logic [103:0] b;
      int           len;
      int           mode;   // 0 back-to-back, 1 toggling valid, 2 random gaps
      bit           pulse;  // pulse start while in DATA
      bit           e_done;
      bit           e_err;
      int           e_words;
      logic [31:0]  w0;
      logic [31:0]  w1;
   } vec_t;

   wr_t         wlog[$];
   logic [7:0]  stream[$];
   logic [31:0] exp_wr[$];
   int          tests = 0;
   int          fails = 0;
   int          idx;
   int          cyc;

   // Every cycle with any bank enable is logged, sampled mid-cycle.
   always @(negedge clk)
      if (mem_we != 4'h0) wlog.push_back('{a: mem_addr, d: mem_wdata, we: mem_we});

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_load();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("start_to_hdr_ready", rx_ready, 1);
   endtask

   // Offers stream[idx..upto-1]; caller sits at a negedge on entry and exit.
   task automatic send(input int upto, input int mode, input bit pulse);
      bit a;
      cyc = 0;
      while (idx < upto && cyc < 2000) begin
         case (mode)
            0:       rx_valid = 1'b1;
            1:       rx_valid = (cyc % 2 == 0);
            default: rx_valid = ($urandom_range(0, 3) != 0);
         endcase
         rx_data = rx_valid ? stream[idx] : 8'($urandom);
         start   = pulse && (idx == 6);
         a = rx_valid && rx_ready;
         @(posedge clk);
         if (a) idx++;
         cyc++;
         @(negedge clk);
      end
      rx_valid = 1'b0;
      start    = 1'b0;
      if (cyc >= 2000) chk("send_timeout", idx, upto);
   endtask

   task automatic model(output bit e_done, output bit e_err, output int e_words);
      logic [31:0] n;
      logic [7:0]  sum;
      exp_wr.delete();
      n = {stream[3], stream[2], stream[1], stream[0]};
      e_done = 0; e_err = 0; e_words = 0;
      if (n > 32'd16384) begin
         e_err = 1;
         return;
      end
      for (int k = 0; k < int'(n); k++)
         exp_wr.push_back({stream[4+4*k+3], stream[4+4*k+2], stream[4+4*k+1], stream[4+4*k]});
      sum = 8'd0;
      for (int i = 4; i < stream.size(); i++) sum += stream[i];
      e_words = int'(n);
      if (sum == 8'd0) e_done = 1; else e_err = 1;
   endtask

   task automatic run_and_compare(input string tag, input int mode, input bit pulse,
                                  input bit e_done, input bit e_err, input int e_words);
      wlog.delete();
      idx = 0;
      start_load();
      send(stream.size(), mode, pulse);
      chk({tag, " status_next_cycle"}, done | error, 1);
      chk({tag, " ready_low"}, rx_ready, 0);
      repeat (2) @(negedge clk);
      chk({tag, " done"}, done, e_done);
      chk({tag, " error"}, error, e_err);
      chk({tag, " cpu_hold"}, cpu_hold, !e_done);
      chk({tag, " words_loaded"}, words_loaded, e_words);
      chk({tag, " write_count"}, wlog.size(), exp_wr.size());
      for (int k = 0; k < wlog.size() && k < exp_wr.size(); k++) begin
         chk({tag, " wr_addr"}, wlog[k].a, k);
         chk({tag, " wr_data"}, wlog[k].d, exp_wr[k]);
         chk({tag, " wr_we"}, wlog[k].we, 4'hF);
      end
   endtask

   task automatic load_vec(input vec_t v);
      stream.delete();
      for (int i = 0; i < v.len; i++) stream.push_back(v.b[8*(v.len-1-i) +: 8]);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " rx_ready"}, rx_ready, 0);
      chk({tag, " mem_we"}, mem_we, 0);
      chk({tag, " mem_addr"}, mem_addr, 0);
      chk({tag, " mem_wdata"}, mem_wdata, 0);
      chk({tag, " cpu_hold"}, cpu_hold, 1);
      chk({tag, " done_error"}, {done, error}, 0);
      chk({tag, " words_loaded"}, words_loaded, 0);
   endtask

   vec_t vecs[8];

   initial begin
      bit   ed, ee;
      int   ew;
      int   n;
      logic [7:0] s;

      vecs[0] = '{"two_word",      104'h02000000_13000000_78563412_D9, 13, 0, 0, 1, 0, 2, 32'h13, 32'h12345678};
      vecs[1] = '{"bad_csum",      104'h02000000_13000000_78563412_DA, 13, 0, 0, 0, 1, 2, 32'h13, 32'h12345678};
      vecs[2] = '{"oversize",      104'h01400000,                       4, 0, 0, 0, 1, 0, 0, 0};
      vecs[3] = '{"oversize_big",  104'h00000001,                       4, 0, 0, 0, 1, 0, 0, 0};
      vecs[4] = '{"zero_words",    104'h00000000_00,                    5, 0, 0, 1, 0, 0, 0, 0};
      vecs[5] = '{"zero_bad",      104'h00000000_01,                    5, 0, 0, 0, 1, 0, 0, 0};
      vecs[6] = '{"backpressure",  104'h02000000_13000000_78563412_D9, 13, 1, 1, 1, 0, 2, 32'h13, 32'h12345678};
      vecs[7] = '{"random_gaps",   104'h02000000_13000000_78563412_D9, 13, 2, 1, 1, 0, 2, 32'h13, 32'h12345678};

      // Reset with random inputs toggling.
      rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) begin
         @(negedge clk);
         start = 1'($urandom); rx_valid = 1'($urandom); rx_data = 8'($urandom);
      end
      #1 check_reset_values("reset");
      @(negedge clk);
      start = 1'b0; rx_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         load_vec(vecs[i]);
         exp_wr.delete();
         if (vecs[i].e_words > 0) exp_wr.push_back(vecs[i].w0);
         if (vecs[i].e_words > 1) exp_wr.push_back(vecs[i].w1);
         run_and_compare(vecs[i].name, vecs[i].mode, vecs[i].pulse,
                         vecs[i].e_done, vecs[i].e_err, vecs[i].e_words);
      end

      // Reset after word 0 is written, then a clean reload.
      load_vec(vecs[0]);
      wlog.delete();
      idx = 0;
      start_load();
      send(9, 0, 0);
      chk("midreset pre_write_count", wlog.size(), 1);
      rst_n = 1'b0;
      #1 check_reset_values("midreset");
      wlog.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rx_valid = 1'b1; rx_data = 8'hA5;
      repeat (3) @(negedge clk);
      chk("midreset idle_ready", rx_ready, 0);
      chk("midreset no_writes", wlog.size(), 0);
      rx_valid = 1'b0;
      model(ed, ee, ew);
      run_and_compare("reload", 0, 0, ed, ee, ew);

      // Randomized streams against the reference model.
      for (int t = 0; t < 40; t++) begin
         stream.delete();
         if ($urandom_range(0, 9) == 0) begin
            n = 16385 + $urandom_range(0, 1000);
            for (int b = 0; b < 4; b++) stream.push_back(8'(n >> (8*b)));
         end else begin
            n = $urandom_range(0, 8);
            for (int b = 0; b < 4; b++) stream.push_back(8'(n >> (8*b)));
            s = 8'd0;
            for (int b = 0; b < 4*n; b++) begin
               stream.push_back(8'($urandom));
               s += stream[stream.size()-1];
            end
            s = 8'd0 - s;
            if ($urandom_range(0, 3) == 0) s += 8'($urandom_range(1, 255));
            stream.push_back(s);
         end
         model(ed, ee, ew);
         run_and_compare($sformatf("rand%0d", t), $urandom_range(0, 2), 1'($urandom), ed, ee, ew);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
